branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 32, total BTB entries (power of two, >= WAYS).
REQ-002 SHALL have parameter WAYS, default 2, associativity (power of two, 1..4); SETS = ENTRIES/WAYS, IDX_W = log2(SETS), TAG_W = 30-IDX_W.
REQ-003 SHALL have parameter CTR_W, default 2, saturating counter width (2..4).
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return stack entries (power of two).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port lookup_fire, input, 1, fetch PC accepted this cycle (not stalled).
REQ-008 SHALL have port lookup_pc, input, 32, fetch PC.
REQ-009 SHALL have ports pred_hit, pred_taken (output, 1 each) and pred_target (output, 32): hit flag, taken prediction, next-PC prediction.
REQ-010 SHALL have ports update_valid (input, 1), update_pc (input, 32), update_target (input, 32), update_taken (input, 1): resolved branch from EX.
REQ-011 SHALL have ports update_is_call, update_is_ret (input, 1 each): resolved instruction type.

Function
REQ-012 SHALL derive index = pc[IDX_W+1:2] and tag = pc[31:IDX_W+2] for both lookup and update.
REQ-013 SHALL look up combinationally, zero latency; hit = any way in the set valid with matching tag; on multiple matches, the lowest-numbered way wins.
REQ-014 SHALL drive pred_taken = hit && counter MSB; pred_target = stored target when taken, else lookup_pc+4 (32-bit wrap).
REQ-015 SHALL apply an update at the rising edge after update_valid; a same-cycle lookup of the same entry returns pre-update contents.
REQ-016 On update hit with update_taken: target <= update_target; counter saturating +1, except a changed target forces counter to weak-taken (1 << (CTR_W-1)).
REQ-017 On update hit with !update_taken: counter saturating -1 (floor 0); target unchanged.
REQ-018 On update miss with update_taken: SHALL allocate the lowest invalid way, else the way at the set's round-robin pointer, then advance that pointer modulo WAYS; the new entry gets valid=1, tag, target, weak-taken counter, and call/ret type bits.
REQ-019 On update miss with !update_taken: SHALL NOT allocate.
REQ-020 Each entry SHALL store is_call/is_ret bits, rewritten on every update that writes the entry.

Reset
REQ-021 While rst_n=0: all valid bits, counters, type bits, round-robin pointers, RAS pointer and RAS count SHALL be 0.
REQ-022 While rst_n=0: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4; update_valid is ignored.
REQ-023 Reset assertion mid-update SHALL leave the table fully cleared; no partial writes survive.

Configuration
REQ-024 Macro BP_RAS_EN, when defined, SHALL compile in a RAS_DEPTH-entry circular return-address stack.
REQ-025 With BP_RAS_EN: a lookup_fire hit on a taken is_call entry SHALL push lookup_pc+4. A taken is_ret hit SHALL predict the stack top as pred_target and pop on lookup_fire. Push on full SHALL overwrite the oldest entry, count saturating at RAS_DEPTH. Pop on empty SHALL use the BTB target, count staying 0.
REQ-026 Without BP_RAS_EN: no stack storage; type bits are stored but ignored; ret entries predict from the BTB target.

Verification
REQ-027 Reset then lookup 0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104.
REQ-028 Update pc=0x100, target=0x200, taken; next cycle lookup 0x100 -> hit=1, taken=1, target=0x200; two not-taken updates -> taken=0, target=0x104.
REQ-029 WAYS=2, SETS=16: taken updates for 0x100, 0x140, 0x180 (same set) -> 0x100 evicted (round-robin), 0x140 and 0x180 hit.
REQ-030 CTR_W=2: four taken updates on one entry -> counter 3 (saturated); then taken update with new target 0x300 -> counter 2, target 0x300.
REQ-031 BP_RAS_EN, RAS_DEPTH=4: five call hits at 0x10,0x20,0x30,0x40,0x50, then five ret hits -> targets 0x54,0x44,0x34,0x24, then BTB target.
REQ-032 Same-cycle update and lookup on 0x100 -> lookup returns old prediction; next cycle returns new.

Source files
------------

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Set-associative BTB with saturating counters; optional return
//            address stack compiled in with `define BP_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES   = 32,
    parameter int WAYS      = 2,
    parameter int CTR_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lookup_fire,
    input  logic [31:0] lookup_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        update_is_call,
    input  logic        update_is_ret
);
    localparam int c_SETS  = ENTRIES / WAYS;
    localparam int c_IDX_W = $clog2(c_SETS);
    localparam int c_TAG_W = 30 - c_IDX_W;
    localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [CTR_W-1:0] c_CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] c_CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};

    // Type field is {is_call, is_ret}
    logic               r_valid  [c_SETS][WAYS];
    logic [c_TAG_W-1:0] r_tag    [c_SETS][WAYS];
    logic [31:0]        r_target [c_SETS][WAYS];
    logic [CTR_W-1:0]   r_ctr    [c_SETS][WAYS];
    logic [1:0]         r_type   [c_SETS][WAYS];
    logic [c_WAY_W-1:0] r_rr     [c_SETS];

    logic [c_IDX_W-1:0] w_l_idx, w_u_idx;
    logic [c_TAG_W-1:0] w_l_tag, w_u_tag;
    logic               w_l_hit, w_u_hit, w_free_found;
    logic [c_WAY_W-1:0] w_l_way, w_u_way, w_alloc_way;
    logic [1:0]         w_l_type;
    logic [31:0]        w_btb_target, w_pc_plus4, w_ras_top;
    logic [CTR_W-1:0]   w_u_ctr;
    logic [31:0]        w_u_tgt;
    logic               w_btb_taken, w_use_ras;

    assign w_l_idx    = lookup_pc[c_IDX_W+1:2];
    assign w_l_tag    = lookup_pc[31:c_IDX_W+2];
    assign w_u_idx    = update_pc[c_IDX_W+1:2];
    assign w_u_tag    = update_pc[31:c_IDX_W+2];
    assign w_pc_plus4 = lookup_pc + 32'd4;

    // Descending scan so the lowest-numbered matching way wins
    always_comb begin
        w_l_hit = 1'b0;
        w_l_way = '0;
        w_u_hit = 1'b0;
        w_u_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_l_idx][w] && r_tag[w_l_idx][w] == w_l_tag) begin
                w_l_hit = 1'b1;
                w_l_way = c_WAY_W'(w);
            end
            if (r_valid[w_u_idx][w] && r_tag[w_u_idx][w] == w_u_tag) begin
                w_u_hit = 1'b1;
                w_u_way = c_WAY_W'(w);
            end
        end
    end

    always_comb begin
        w_free_found = 1'b0;
        w_alloc_way  = r_rr[w_u_idx];
        for (int w = 0; w < WAYS; w++) begin
            if (!r_valid[w_u_idx][w] && !w_free_found) begin
                w_free_found = 1'b1;
                w_alloc_way  = c_WAY_W'(w);
            end
        end
    end

    assign w_l_type     = r_type[w_l_idx][w_l_way];
    assign w_btb_target = r_target[w_l_idx][w_l_way];
    assign w_btb_taken  = w_l_hit && r_ctr[w_l_idx][w_l_way][CTR_W-1];
    assign w_u_ctr      = r_ctr[w_u_idx][w_u_way];
    assign w_u_tgt      = r_target[w_u_idx][w_u_way];

    assign pred_hit    = w_l_hit;
    assign pred_taken  = w_btb_taken;
    assign pred_target = !w_btb_taken ? w_pc_plus4 :
                         w_use_ras    ? w_ras_top  : w_btb_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < c_SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w]  <= 1'b0;
                    r_tag[s][w]    <= '0;
                    r_target[s][w] <= '0;
                    r_ctr[s][w]    <= '0;
                    r_type[s][w]   <= '0;
                end
            end
        end else if (update_valid) begin
            if (w_u_hit) begin
                r_type[w_u_idx][w_u_way] <= {update_is_call, update_is_ret};
                if (update_taken) begin
                    r_target[w_u_idx][w_u_way] <= update_target;
                    // A retargeted branch restarts at weak-taken confidence
                    if (w_u_tgt != update_target)
                        r_ctr[w_u_idx][w_u_way] <= c_CTR_WEAK;
                    else if (w_u_ctr != c_CTR_MAX)
                        r_ctr[w_u_idx][w_u_way] <= w_u_ctr + 1'b1;
                end else if (w_u_ctr != '0) begin
                    r_ctr[w_u_idx][w_u_way] <= w_u_ctr - 1'b1;
                end
            end else if (update_taken) begin
                r_valid[w_u_idx][w_alloc_way]  <= 1'b1;
                r_tag[w_u_idx][w_alloc_way]    <= w_u_tag;
                r_target[w_u_idx][w_alloc_way] <= update_target;
                r_ctr[w_u_idx][w_alloc_way]    <= c_CTR_WEAK;
                r_type[w_u_idx][w_alloc_way]   <= {update_is_call, update_is_ret};
                r_rr[w_u_idx] <= (WAYS == 1) ? '0 : r_rr[w_u_idx] + 1'b1;
            end
        end
    end

`ifdef BP_RAS_EN
    localparam int c_RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_RAS_CNT_W = $clog2(RAS_DEPTH + 1);

    logic [31:0]            r_ras [RAS_DEPTH];
    logic [c_RAS_PTR_W-1:0] r_ras_ptr, w_ptr_inc, w_ptr_dec;
    logic [c_RAS_CNT_W-1:0] r_ras_cnt;
    logic                   w_push, w_pop;

    // r_ras_ptr is the next free slot; the top sits one below it
    assign w_ptr_inc = (r_ras_ptr == c_RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + 1'b1;
    assign w_ptr_dec = (r_ras_ptr == '0) ? c_RAS_PTR_W'(RAS_DEPTH - 1) : r_ras_ptr - 1'b1;
    assign w_ras_top = r_ras[w_ptr_dec];
    assign w_use_ras = (w_l_type == 2'b01) && (r_ras_cnt != '0);
    assign w_push    = lookup_fire && w_btb_taken && w_l_type[1];
    assign w_pop     = lookup_fire && w_btb_taken && w_use_ras;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_push) begin
            r_ras_ptr <= w_ptr_inc;
            if (r_ras_cnt != c_RAS_CNT_W'(RAS_DEPTH))
                r_ras_cnt <= r_ras_cnt + 1'b1;
        end else if (w_pop) begin
            r_ras_ptr <= w_ptr_dec;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_ras[r_ras_ptr] <= w_pc_plus4;
    end
`else
    // No stack: the "top" aliases the BTB target so returns predict from the BTB
    assign w_ras_top = w_btb_target;
    assign w_use_ras = lookup_fire && (w_l_type == 2'b01);
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed scoreboard bench for branch_predictor (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_fire;
    logic [31:0] lookup_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc, update_target;
    logic        update_taken, update_is_call, update_is_ret;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_fire   (lookup_fire),
        .lookup_pc     (lookup_pc),
        .pred_hit      (pred_hit),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .update_valid  (update_valid),
        .update_pc     (update_pc),
        .update_target (update_target),
        .update_taken  (update_taken),
        .update_is_call(update_is_call),
        .update_is_ret (update_is_ret)
    );

    typedef struct {
        string       tag;
        logic [33:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_pred(input string tag, input logic ehit, input logic etaken,
                               input logic [31:0] etgt);
        exp_t e;
        e.tag = tag;
        e.exp = {ehit, etaken, etgt};
        sb.push_back(e);
    endtask

    task automatic check_pred();
        exp_t        e;
        logic [33:0] obs;
        obs = {pred_hit, pred_taken, pred_target};
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h with no expected entry required", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.exp) n_pass++;
            else $error("FAIL %s: hit/taken/target observed %h expected %h", e.tag, obs, e.exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic fire,
                        input logic ehit, input logic etaken, input logic [31:0] etgt);
        lookup_pc   = pc;
        lookup_fire = fire;
        expect_pred(tag, ehit, etaken, etgt);
        @(negedge clk);
        check_pred();
        @(posedge clk);
        #1;
        lookup_fire = 1'b0;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic taken,
                       input logic is_call = 1'b0, input logic is_ret = 1'b0);
        update_pc      = pc;
        update_target  = tgt;
        update_taken   = taken;
        update_is_call = is_call;
        update_is_ret  = is_ret;
        update_valid   = 1'b1;
        @(posedge clk);
        #1;
        update_valid = 1'b0;
    endtask

    logic [31:0] call_pcs [5];
    logic [31:0] ret_tgts [5];

    initial begin
        rst_n = 1'b0; lookup_fire = 1'b0; lookup_pc = 32'h100;
        update_valid = 1'b1; update_pc = 32'h100; update_target = 32'h200;
        update_taken = 1'b1; update_is_call = 1'b0; update_is_ret = 1'b0;

        // Reset with a pending update that must be ignored
        repeat (2) @(posedge clk);
        expect_pred("in_reset", 1'b0, 1'b0, 32'h104);
        @(negedge clk);
        check_pred();
        update_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        look("post_reset_miss", 32'h100, 1'b0, 1'b0, 1'b0, 32'h104);
        upd(32'h100, 32'h200, 1'b1);
        look("alloc_hit", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 32'h200, 1'b0);
        look("nt_once", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 32'h200, 1'b0);
        look("nt_twice", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 32'h200, 1'b0);
        upd(32'h100, 32'h200, 1'b1);
        look("floor_then_t", 32'h100, 1'b0, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 32'h200, 1'b1);
        look("floor_then_tt", 32'h100, 1'b0, 1'b1, 1'b1, 32'h200);

        // Saturation and retarget to weak-taken
        repeat (4) upd(32'h208, 32'h280, 1'b1);
        look("sat_taken", 32'h208, 1'b0, 1'b1, 1'b1, 32'h280);
        upd(32'h208, 32'h300, 1'b1);
        look("retarget", 32'h208, 1'b0, 1'b1, 1'b1, 32'h300);
        upd(32'h208, 32'h300, 1'b0);
        look("retarget_weak", 32'h208, 1'b0, 1'b1, 1'b0, 32'h20C);

        // Round-robin eviction in set 0
        upd(32'h140, 32'h1400, 1'b1);
        upd(32'h180, 32'h1800, 1'b1);
        look("evict_100", 32'h100, 1'b0, 1'b0, 1'b0, 32'h104);
        look("keep_140", 32'h140, 1'b0, 1'b1, 1'b1, 32'h1400);
        look("keep_180", 32'h180, 1'b0, 1'b1, 1'b1, 32'h1800);
        upd(32'h1C0, 32'h1C00, 1'b1);
        look("evict_140", 32'h140, 1'b0, 1'b0, 1'b0, 32'h144);
        look("rr_keep_180", 32'h180, 1'b0, 1'b1, 1'b1, 32'h1800);

        // Not-taken miss must not allocate
        upd(32'h300, 32'h3000, 1'b0);
        look("nt_no_alloc", 32'h300, 1'b0, 1'b0, 1'b0, 32'h304);
        look("nt_no_evict", 32'h180, 1'b0, 1'b1, 1'b1, 32'h1800);

        // Same-cycle update and lookup sees old contents
        update_pc = 32'h100; update_target = 32'h600; update_taken = 1'b1;
        update_is_call = 1'b0; update_is_ret = 1'b0; update_valid = 1'b1;
        lookup_pc = 32'h100;
        expect_pred("same_cycle_old", 1'b0, 1'b0, 32'h104);
        @(negedge clk);
        check_pred();
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        look("same_cycle_new", 32'h100, 1'b0, 1'b1, 1'b1, 32'h600);

        look("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0);

        // Calls and returns
        call_pcs = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
`ifdef BP_RAS_EN
        ret_tgts = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h900};
`else
        ret_tgts = '{32'h900, 32'h900, 32'h900, 32'h900, 32'h900};
`endif
        for (int i = 0; i < 5; i++) upd(call_pcs[i], 32'h1000 + call_pcs[i], 1'b1, 1'b1, 1'b0);
        upd(32'h804, 32'h900, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            look($sformatf("call_%0d", i), call_pcs[i], 1'b1, 1'b1, 1'b1, 32'h1000 + call_pcs[i]);
        for (int i = 0; i < 5; i++)
            look($sformatf("ret_%0d", i), 32'h804, 1'b1, 1'b1, 1'b1, ret_tgts[i]);

        // Reset asserted while an update is pending clears everything
        update_pc = 32'h700; update_target = 32'h7000; update_taken = 1'b1;
        update_valid = 1'b1;
        lookup_pc = 32'h208;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_pred("mid_reset", 1'b0, 1'b0, 32'h20C);
        check_pred();
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        rst_n = 1'b1;
        look("cleared_208", 32'h208, 1'b0, 1'b0, 1'b0, 32'h20C);
        look("cleared_700", 32'h700, 1'b0, 1'b0, 1'b0, 32'h704);
        look("cleared_804", 32'h804, 1'b0, 1'b0, 1'b0, 32'h808);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
